// File: rtl/pi_output_conditioner_if.sv
// Sample stream between the PI controller, the output conditioner and the DAC.
//   in_data   signed controller sample
//   in_valid  in_data qualifier, one cycle per sample
//   out_data  conditioned sample to the DAC (encoding chosen by the conditioner)
//   out_valid out_data pending
//   out_ready DAC accepts when out_valid && out_ready
// master: the controller/DAC side driving samples in and ready back.
// slave:  the conditioner.
interface pi_output_conditioner_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic        [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/pi_output_conditioner.sv
// PI controller output conditioner: clamps each controller sample to
// [limit_min, limit_max], slew-limits it by max_step per sample, and holds it
// in a single-entry valid/ready register for the DAC. On disable the output is
// ramped to park_value so the actuator never sees a step.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         1 = track controller, 1->0 starts ramp to park_value
//   bus            sample stream (in_data/in_valid in, out_data/out_valid/out_ready)
//   limit_min/max  signed clamp window
//   max_step       unsigned max |change| per sample, 0 = no slew limit
//   park_value     signed value reached by the ramp
//   limiting       last processed sample was clamped or slew-limited
//   overrun_count  saturating count of samples overwritten before acceptance
//   running        1 while tracking the controller
module pi_output_conditioner #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int          OFFSET_BINARY = 1,
  parameter int unsigned RAMP_DIV      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  pi_output_conditioner_if.slave       bus,
  input  logic signed [DATA_WIDTH-1:0] limit_min,
  input  logic signed [DATA_WIDTH-1:0] limit_max,
  input  logic        [DATA_WIDTH-1:0] max_step,
  input  logic signed [DATA_WIDTH-1:0] park_value,
  output logic                         limiting,
  output logic [15:0]                  overrun_count,
  output logic                         running
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;
  typedef logic signed [W:0] wide_t;

  function automatic logic [W-1:0] encode(input logic [W-1:0] v);
    return (OFFSET_BINARY != 0) ? {~v[W-1], v[W-2:0]} : v;
  endfunction

  state_t state_q, state_d;

  logic                run_go;
  logic                ramp_tick;
  logic [CW-1:0]       cnt_q;

  logic                s1_valid_q;
  logic signed [W-1:0] c_q;
  logic                hit_q;
  logic signed [W-1:0] prev_q;
  logic        [W-1:0] out_data_q;
  logic                out_valid_q;

  logic signed [W-1:0] clamp_lo, clamp_c;
  logic                clamp_hit;
  logic                slew_on;
  wide_t               step_w, diff, rdiff;
  logic signed [W-1:0] y, ramp_y, upd_val;
  logic                sample_upd, upd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = RAMP;
      RAMP: begin
        if (enable)                    state_d = RUN;
        else if (prev_q == park_value) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Samples only advance while the FSM stays in RUN, so anything still in the
  // pipeline on the RUN->RAMP edge is dropped rather than emitted.
  always_comb begin
    running   = (state_q == RUN);
    run_go    = (state_q == RUN) && enable;
    ramp_tick = (state_q == RAMP) && !enable && (prev_q != park_value) &&
                (cnt_q == CW'(RAMP_DIV - 1));
  end

  // ---------------- datapath ----------------
  always_comb begin
    // Taking max first then min makes an inverted window yield limit_max.
    clamp_lo  = ($signed(bus.in_data) < limit_min) ? limit_min : $signed(bus.in_data);
    clamp_c   = (clamp_lo > limit_max) ? limit_max : clamp_lo;
    clamp_hit = (clamp_c != $signed(bus.in_data));

    slew_on = (max_step != '0);
    step_w  = {1'b0, max_step};
    diff    = {c_q[W-1], c_q} - {prev_q[W-1], prev_q};
    rdiff   = {park_value[W-1], park_value} - {prev_q[W-1], prev_q};

    y = c_q;
    if (slew_on && diff > step_w)       y = prev_q + max_step;
    else if (slew_on && diff < -step_w) y = prev_q - max_step;

    ramp_y = park_value;
    if (slew_on && (rdiff > step_w || rdiff < -step_w)) begin
      ramp_y = rdiff[W] ? (prev_q - max_step) : (prev_q + max_step);
    end

    sample_upd = run_go && s1_valid_q;
    upd        = sample_upd || ramp_tick;
    upd_val    = sample_upd ? y : ramp_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      c_q           <= '0;
      hit_q         <= 1'b0;
      prev_q        <= '0;
      out_data_q    <= encode('0);
      out_valid_q   <= 1'b0;
      limiting      <= 1'b0;
      overrun_count <= '0;
      cnt_q         <= '0;
    end else begin
      s1_valid_q <= run_go && bus.in_valid;
      if (run_go && bus.in_valid) begin
        c_q   <= clamp_c;
        hit_q <= clamp_hit;
      end

      // Divider only runs in RAMP, so every RAMP entry starts from zero.
      if (state_q == RAMP && cnt_q != CW'(RAMP_DIV - 1)) cnt_q <= cnt_q + CW'(1);
      else                                               cnt_q <= '0;

      if (upd) begin
        prev_q      <= upd_val;
        out_data_q  <= encode(upd_val);
        out_valid_q <= 1'b1;
        if (out_valid_q && !bus.out_ready && overrun_count != 16'hFFFF)
          overrun_count <= overrun_count + 16'd1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (sample_upd)            limiting <= hit_q || (y != c_q);
      else if (state_q == RAMP)  limiting <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_pi_output_conditioner.sv
module tb_pi_output_conditioner;
  localparam int W  = 16;
  localparam int RD = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic signed [W-1:0] limit_min, limit_max, park_value;
  logic        [W-1:0] max_step;
  logic                limiting;
  logic [15:0]         overrun_count;
  logic                running;

  int errors = 0;
  int checks = 0;

  pi_output_conditioner_if #(.DATA_WIDTH(W)) bus ();

  pi_output_conditioner #(
    .DATA_WIDTH(W),
    .OFFSET_BINARY(1),
    .RAMP_DIV(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .limit_min(limit_min),
    .limit_max(limit_max),
    .max_step(max_step),
    .park_value(park_value),
    .limiting(limiting),
    .overrun_count(overrun_count),
    .running(running)
  );

  always #5 clk = ~clk;

  // Offset-binary encoding of a signed value.
  function automatic logic [15:0] enc(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {~t[15], t[14:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    limit_min = 16'sh8000; limit_max = 16'sh7FFF; max_step = '0; park_value = '0;
    tick(); tick();
    checks++; if (bus.out_data !== 16'h8000) begin errors++; $display("FAIL reset_out_data got %h want 8000", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (limiting !== 1'b0) begin errors++; $display("FAIL reset_limiting got %b want 0", limiting); end
    checks++; if (overrun_count !== 16'h0) begin errors++; $display("FAIL reset_overrun got %h want 0", overrun_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    reset = 1'b0;
  endtask

  task automatic test_clamp();
    enable = 1'b1; limit_min = 16'shE000; limit_max = 16'sh2000; max_step = '0;
    tick(); tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL clamp_running got %b want 1", running); end
    send(16'h3000);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clamp_latency got valid=%b want 0 after one edge", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'hA000) begin errors++; $display("FAIL clamp_data got %h want a000", bus.out_data); end
    checks++; if (limiting !== 1'b1) begin errors++; $display("FAIL clamp_limiting got %b want 1", limiting); end
  endtask

  task automatic test_slew();
    limit_min = 16'sh8000; limit_max = 16'sh7FFF; max_step = '0;
    send(16'h0000); tick();
    max_step = 16'h0100;
    for (int i = 1; i <= 4; i++) begin
      send(16'h1000); tick();
      checks++; if (bus.out_data !== enc(i * 256)) begin errors++; $display("FAIL slew_step%0d got %h want %h", i, bus.out_data, enc(i * 256)); end
      checks++; if (limiting !== 1'b1) begin errors++; $display("FAIL slew_lim%0d got %b want 1", i, limiting); end
    end
    send(16'h0450); tick();
    checks++; if (bus.out_data !== enc(16'h0450)) begin errors++; $display("FAIL slew_final got %h want %h", bus.out_data, enc(16'h0450)); end
    checks++; if (limiting !== 1'b0) begin errors++; $display("FAIL slew_final_lim got %b want 0", limiting); end
  endtask

  task automatic test_backpressure();
    int accepts;
    tick();
    bus.out_ready = 1'b0; max_step = '0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0100; tick();
    bus.in_data = 16'h0200; tick();
    bus.in_data = 16'h0300; tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    checks++; if (bus.out_data !== enc(16'h0300)) begin errors++; $display("FAIL bp_data got %h want %h", bus.out_data, enc(16'h0300)); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", bus.out_valid); end
    checks++; if (overrun_count !== 16'd2) begin errors++; $display("FAIL bp_overrun got %0d want 2", overrun_count); end
    bus.out_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid && bus.out_ready) accepts++;
      tick();
    end
    checks++; if (accepts != 1) begin errors++; $display("FAIL bp_accepts got %0d want 1", accepts); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ramp();
    int exp_vals[$];
    int got_vals[$];
    int got_cyc[$];
    int p;
    limit_max = 16'sh0800; max_step = '0;
    send(16'h0900); tick();
    checks++; if (bus.out_data !== enc(16'h0800) || limiting !== 1'b1) begin errors++; $display("FAIL ramp_setup got %h/%b want %h/1", bus.out_data, limiting, enc(16'h0800)); end
    limit_max = 16'sh7FFF; park_value = '0; max_step = 16'h0300;
    p = 16'h0800;
    while (p != 0) p = (p > 16'h0300) ? p - 16'h0300 : 0;
    p = 16'h0800;
    while (p != 0) begin p = (p > 16'h0300) ? p - 16'h0300 : 0; exp_vals.push_back(p); end
    enable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid) begin got_vals.push_back(int'($signed(bus.out_data ^ 16'h8000))); got_cyc.push_back(c); end
    end
    checks++; if (got_vals.size() != exp_vals.size()) begin errors++; $display("FAIL ramp_count got %0d want %0d", got_vals.size(), exp_vals.size()); end
    for (int i = 0; i < exp_vals.size() && i < got_vals.size(); i++) begin
      checks++; if (got_vals[i] != exp_vals[i]) begin errors++; $display("FAIL ramp_val%0d got %h want %h", i, got_vals[i], exp_vals[i]); end
      if (i > 0) begin
        checks++; if (got_cyc[i] - got_cyc[i-1] != RD) begin errors++; $display("FAIL ramp_spacing%0d got %0d want %0d", i, got_cyc[i] - got_cyc[i-1], RD); end
      end
    end
    checks++; if (limiting !== 1'b0) begin errors++; $display("FAIL ramp_limiting got %b want 0", limiting); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ramp_running got %b want 0", running); end
    park_value = 16'sh1234;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== enc(0)) begin errors++; $display("FAIL idle_hold got %b/%h want 0/%h", bus.out_valid, bus.out_data, enc(0)); end
    end
  endtask

  task automatic test_reenable_reset();
    park_value = '0; max_step = '0; enable = 1'b1;
    tick(); tick();
    send(16'h0800); tick();
    max_step = 16'h0100; enable = 1'b0;
    repeat (12) tick();
    checks++; if (bus.out_data !== enc(16'h0700)) begin errors++; $display("FAIL reen_ramp got %h want %h", bus.out_data, enc(16'h0700)); end
    enable = 1'b1; tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reen_running got %b want 1", running); end
    max_step = '0;
    send(16'h0123); tick();
    checks++; if (bus.out_data !== enc(16'h0123) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL reen_sample got %h/%b want %h/1", bus.out_data, bus.out_valid, enc(16'h0123)); end
    bus.out_ready = 1'b0; enable = 1'b0; max_step = 16'h0010;
    send(16'h0555);
    repeat (11) tick();
    checks++; if (bus.out_data !== enc(16'h0113)) begin errors++; $display("FAIL reen_discard got %h want %h", bus.out_data, enc(16'h0113)); end
    checks++; if (overrun_count !== 16'd3) begin errors++; $display("FAIL reen_overrun got %0d want 3", overrun_count); end
    park_value = 16'sh0400;
    reset = 1'b1; tick();
    checks++; if (bus.out_data !== 16'h8000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out got %h/%b want 8000/0", bus.out_data, bus.out_valid); end
    checks++; if (overrun_count !== 16'h0 || running !== 1'b0 || limiting !== 1'b0) begin errors++; $display("FAIL midreset_status got ovr=%0d run=%b lim=%b want 0/0/0", overrun_count, running, limiting); end
    reset = 1'b0; bus.out_ready = 1'b1;
    repeat (20) tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h8000) begin errors++; $display("FAIL postreset_idle got %b/%h want 0/8000", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_inverted_limits();
    park_value = '0; enable = 1'b1; tick(); tick();
    limit_min = 16'sh1000; limit_max = 16'sh0800; max_step = '0;
    send(16'h0000); tick();
    checks++; if (bus.out_data !== enc(16'h0800)) begin errors++; $display("FAIL inv_data got %h want %h", bus.out_data, enc(16'h0800)); end
    checks++; if (limiting !== 1'b1) begin errors++; $display("FAIL inv_limiting got %b want 1", limiting); end
  endtask

  // Random RUN traffic against an event-level model: one pending sample,
  // output register with latest-wins overwrite and overrun counting.
  task automatic test_random();
    int m_prev, m_ovr, lo, hi, ms, in_i, c, y;
    bit m_valid, m_lim, m_s1, s1_hit, p_valid, p_ready;
    int s1_c;
    logic [15:0] r1, r2, m_data;
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    tick(); tick();
    m_prev = 0; m_ovr = 0; m_valid = 0; m_lim = 0; m_s1 = 0; s1_c = 0; s1_hit = 0;
    m_data = enc(0);
    for (int b = 0; b < 8; b++) begin
      r1 = 16'($urandom); r2 = 16'($urandom);
      lo = int'($signed(r1)); hi = int'($signed(r2));
      if ((lo > hi) != (b == 5)) begin int t; t = lo; lo = hi; hi = t; end
      ms = (b % 3 == 0) ? 0 : int'($urandom_range(1, 16'h2000));
      limit_min = lo[15:0]; limit_max = hi[15:0]; max_step = ms[15:0];
      for (int k = 0; k < 40; k++) begin
        p_valid = (k < 38) ? 1'($urandom_range(0, 1)) : 1'b0;
        p_ready = ($urandom_range(0, 3) != 0);
        r1 = 16'($urandom);
        bus.in_data = r1; bus.in_valid = p_valid; bus.out_ready = p_ready;
        tick();
        if (m_s1) begin
          int d;
          d = s1_c - m_prev;
          if (ms != 0 && d > ms)       y = m_prev + ms;
          else if (ms != 0 && d < -ms) y = m_prev - ms;
          else                         y = s1_c;
          if (m_valid && !p_ready && m_ovr < 65535) m_ovr++;
          m_valid = 1; m_prev = y; m_data = enc(y);
          m_lim = s1_hit || (y != s1_c);
        end else if (m_valid && p_ready) begin
          m_valid = 0;
        end
        m_s1 = p_valid;
        if (p_valid) begin
          in_i = int'($signed(r1));
          c = (in_i < lo) ? lo : in_i;
          c = (c > hi) ? hi : c;
          s1_c = c; s1_hit = (c != in_i);
        end
        checks++; if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid b%0d k%0d got %b want %b", b, k, bus.out_valid, m_valid); end
        checks++; if (bus.out_data !== m_data) begin errors++; $display("FAIL rnd_data b%0d k%0d got %h want %h", b, k, bus.out_data, m_data); end
        checks++; if (limiting !== m_lim) begin errors++; $display("FAIL rnd_lim b%0d k%0d got %b want %b", b, k, limiting, m_lim); end
        checks++; if (overrun_count !== m_ovr[15:0]) begin errors++; $display("FAIL rnd_ovr b%0d k%0d got %0d want %0d", b, k, overrun_count, m_ovr); end
      end
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_slew();
    test_backpressure();
    test_ramp();
    test_reenable_reset();
    test_inverted_limits();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
